// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet RX slot scheduler: widths, defaults,
// FSM state encoding and the slot base-address helper.
package eth_rx_pkg;
  localparam int ADDR_W         = 16;
  localparam int LEN_W          = 16;
  localparam int CNT_W          = 6;
  localparam int NUM_SLOTS_DEF  = 62;
  localparam int SLOT_BYTES_DEF = 1024;
  localparam int RST_HOLD_DEF   = 4;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_LOAD   = 3'd1;
  localparam logic [2:0] ENC_STREAM = 3'd2;
  localparam logic [2:0] ENC_DRAIN  = 3'd3;
  localparam logic [2:0] ENC_RST    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_LOAD   = ENC_LOAD,
    ST_STREAM = ENC_STREAM,
    ST_DRAIN  = ENC_DRAIN,
    ST_RST    = ENC_RST
  } state_t;

  // Slot sizes are powers of two, so the base address is a plain shift.
  function automatic logic [ADDR_W-1:0] slot_base(input logic [CNT_W-1:0] slot,
                                                  input int shift);
    return ADDR_W'(slot) << shift;
  endfunction
endpackage

// File: rtl/eth_rx_len_fifo.sv
// Synchronous first-word-fall-through FIFO holding packet payload lengths.
// Depth need not be a power of two; pointers wrap explicitly.
module eth_rx_len_fifo #(
  parameter int DEPTH = 62,
  parameter int W     = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/eth_rx_slot_sched.sv
// RX packet buffer slot scheduler: queues good-packet lengths, streams each
// slot's payload out of the RAM read port over valid/ready, and pulses the
// RX write-address reset once every slot has drained.
// Optional statistics counters: define ETH_RX_SLOT_SCHED_STATS_EN.
module eth_rx_slot_sched import eth_rx_pkg::*; #(
  parameter int NUM_SLOTS  = NUM_SLOTS_DEF,
  parameter int SLOT_BYTES = SLOT_BYTES_DEF,
  parameter int RST_HOLD   = RST_HOLD_DEF
) (
  input  logic        i_eth_clk,
  input  logic        i_rst,
  input  logic        i_rx_busy,
  input  logic        i_rx_valid_packet,
  input  logic [15:0] i_rx_payload_len,
  output logic        o_eth_rst_waddr,
  output logic [15:0] o_mem_rd_addr,
  input  logic [7:0]  i_mem_rd_data,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  output logic        o_tlast,
  input  logic        i_tready,
  output logic [5:0]  o_pending,
  output logic        o_full,
  output logic [15:0] o_drop_count
`ifdef ETH_RX_SLOT_SCHED_STATS_EN
  ,
  output logic [31:0] o_pkt_streamed,
  output logic [31:0] o_byte_streamed
`endif
);
  localparam int SLOT_SHIFT = $clog2(SLOT_BYTES);
  localparam int HOLD_W     = $clog2(RST_HOLD + 1);

  state_t             state, state_n;
  logic               rx_vld_q, new_pkt, accept, drop;
  logic [CNT_W-1:0]   wr_slots, win_cnt, rd_slot, fifo_cnt;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [LEN_W-1:0]   fifo_dout, len_q, offset_q;
  logic [ADDR_W-1:0]  base_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               inflight_q, inflight_last_q, issue, last_rd, room;
  logic               beat_acc, drain_done, rst_done, busy;
  logic [1:0]         skid_cnt;
  logic [8:0]         skid0, skid1, skid_in;
  logic [2:0]         occ;

  assign new_pkt  = i_rx_valid_packet && !rx_vld_q;
  assign o_full   = (wr_slots == CNT_W'(NUM_SLOTS));
  // Packets arriving during the reset window belong to the restarted slot 0,
  // so the full check is bypassed there.
  assign accept   = new_pkt && !fifo_full && (state == ST_RST || !o_full);
  assign drop     = new_pkt && !accept;
  assign last_rd  = (offset_q == len_q - LEN_W'(1));
  assign beat_acc = o_tvalid && i_tready;
  // Count the beat leaving this cycle so back-to-back reads sustain 1 B/cycle.
  assign occ      = {1'b0, skid_cnt} + {2'b0, inflight_q} - {2'b0, beat_acc};
  assign room     = (occ < 3'd2);
  assign busy     = (state == ST_LOAD) || (state == ST_STREAM) || (state == ST_DRAIN);
  assign o_pending     = fifo_cnt + CNT_W'(busy);
  assign o_mem_rd_addr = base_q + offset_q;
  assign o_tvalid = (skid_cnt != 2'd0);
  assign o_tdata  = skid0[7:0];
  assign o_tlast  = o_tvalid && skid0[8];
  assign skid_in  = {inflight_last_q, i_mem_rd_data};

  eth_rx_len_fifo #(.DEPTH(NUM_SLOTS), .W(LEN_W), .CW(CNT_W)) u_len_fifo (
    .clk   (i_eth_clk),
    .rst   (i_rst),
    .push  (accept),
    .din   (i_rx_payload_len),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and per-cycle strobes.
  always_comb begin
    state_n    = state;
    fifo_pop   = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    rst_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = ST_LOAD;
        end else if (wr_slots != '0 && !i_rx_busy && !i_rx_valid_packet) begin
          state_n = ST_RST;
        end
      end
      ST_LOAD:   state_n = (len_q == '0) ? ST_DRAIN : ST_STREAM;
      ST_STREAM: begin
        if (room) begin
          issue = 1'b1;
          if (last_rd) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (skid_cnt == 2'd0 && !inflight_q) begin
          drain_done = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      ST_RST: begin
        if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
          rst_done = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state, read address generation and slot bookkeeping.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      rx_vld_q        <= 1'b0;
      len_q           <= '0;
      offset_q        <= '0;
      base_q          <= '0;
      rd_slot         <= '0;
      hold_cnt        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      o_eth_rst_waddr <= 1'b0;
    end else begin
      state           <= state_n;
      rx_vld_q        <= i_rx_valid_packet;
      inflight_q      <= issue;
      inflight_last_q <= issue && last_rd;
      o_eth_rst_waddr <= (state_n == ST_RST);
      hold_cnt        <= (state == ST_RST) ? hold_cnt + HOLD_W'(1) : '0;
      if (fifo_pop) begin
        len_q    <= fifo_dout;
        offset_q <= '0;
      end else if (issue) begin
        offset_q <= offset_q + LEN_W'(1);
      end
      if (state == ST_LOAD) base_q <= slot_base(rd_slot, SLOT_SHIFT);
      if (rst_done)        rd_slot <= '0;
      else if (drain_done) rd_slot <= rd_slot + CNT_W'(1);
    end
  end

  // Write-slot count; arrivals during the reset window are re-based to 0.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      wr_slots <= '0;
      win_cnt  <= '0;
    end else if (rst_done) begin
      wr_slots <= win_cnt + CNT_W'(accept);
      win_cnt  <= '0;
    end else if (state == ST_RST) begin
      if (accept) win_cnt <= win_cnt + CNT_W'(1);
    end else if (accept) begin
      wr_slots <= wr_slots + CNT_W'(1);
    end
  end

  // Saturating count of packets lost to a full buffer.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst)                                o_drop_count <= '0;
    else if (drop && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
  end

  // Two-entry skid buffer; the front entry only moves when it is accepted.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      case ({inflight_q, beat_acc})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= skid_in;
          else                  skid1 <= skid_in;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= skid_in;
          end else begin
            skid0 <= skid1;
            skid1 <= skid_in;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ETH_RX_SLOT_SCHED_STATS_EN
  // Wrapping streamed-packet and streamed-byte counters.
  always_ff @(posedge i_eth_clk) begin
    if (i_rst) begin
      o_pkt_streamed  <= '0;
      o_byte_streamed <= '0;
    end else if (beat_acc) begin
      o_byte_streamed <= o_byte_streamed + 32'd1;
      if (o_tlast) o_pkt_streamed <= o_pkt_streamed + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_eth_rx_slot_sched.sv
// Directed + randomized bench for eth_rx_slot_sched. The bench plays the RX
// FSM (tracking which slot each packet lands in), models the RAM as a fixed
// function of address, and compares the accepted AXI-stream beats against
// the byte sequence each packet should produce.
module tb_eth_rx_slot_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_len = '0;
  logic [7:0]  mem_rd_data = '0;
  logic        tready = 1'b1;
  logic        rst_waddr, tvalid, tlast, full;
  logic [15:0] mem_rd_addr, drop_count;
  logic [7:0]  tdata;
  logic [5:0]  pending;
`ifdef ETH_RX_SLOT_SCHED_STATS_EN
  logic [31:0] pkt_streamed, byte_streamed;
`endif

  eth_rx_slot_sched dut (
    .i_eth_clk         (clk),
    .i_rst             (rst),
    .i_rx_busy         (rx_busy),
    .i_rx_valid_packet (rx_valid),
    .i_rx_payload_len  (rx_len),
    .o_eth_rst_waddr   (rst_waddr),
    .o_mem_rd_addr     (mem_rd_addr),
    .i_mem_rd_data     (mem_rd_data),
    .o_tdata           (tdata),
    .o_tvalid          (tvalid),
    .o_tlast           (tlast),
    .i_tready          (tready),
    .o_pending         (pending),
    .o_full            (full),
    .o_drop_count      (drop_count)
`ifdef ETH_RX_SLOT_SCHED_STATS_EN
    ,
    .o_pkt_streamed    (pkt_streamed),
    .o_byte_streamed   (byte_streamed)
`endif
  );

  always #5 clk = ~clk;

  // RAM contents: slot 0 holds its low address byte, other slots are offset.
  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    return a[7:0] + 8'(a[15:10]) * 8'd37;
  endfunction

  always @(posedge clk) mem_rd_data <= ram_byte(mem_rd_addr);

  int         n_assert = 0, n_fail = 0;
  int         hold_viol = 0, rx_slot = 0, drop_m = 0, run = 0, mode = 0;
  bit         stalled = 0, wprev = 0;
  logic [7:0] hold_d = '0;
  logic       hold_l = 1'b0;
  logic [8:0] got[$], exp_q[$];
  int         pulses[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: capture beats that the coming edge will accept, check hold
  // stability, advance, then update ready and observe the waddr pulse.
  task automatic tick();
    if (!rst) begin
      if (stalled && (!tvalid || tdata !== hold_d || tlast !== hold_l)) hold_viol++;
      if (tvalid && tready) got.push_back({tlast, tdata});
      stalled = tvalid && !tready;
      hold_d  = tdata;
      hold_l  = tlast;
    end else begin
      stalled = 0;
    end
    @(posedge clk);
    #1;
    case (mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      2:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
    if (rst_waddr) begin
      if (!wprev) rx_slot = 0;
      run++;
    end else if (run != 0) begin
      pulses.push_back(run);
      run = 0;
    end
    wprev = rst_waddr;
  endtask

  task automatic raise_valid(input int len);
    rx_valid = 1'b1;
    rx_len   = 16'(len);
    if (rx_slot < 62) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), ram_byte(16'(rx_slot * 1024 + i))});
      rx_slot++;
    end else begin
      drop_m++;
    end
    tick();
  endtask

  task automatic send_pkt(input int len);
    rx_busy = 1'b1;
    tick();
    tick();
    rx_busy = 1'b0;
    raise_valid(len);
  endtask

  task automatic end_pkt();
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic pkt(input int len);
    send_pkt(len);
    end_pkt();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while ((got.size() < exp_q.size() || pending != 0) && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_tmo"}, 32'(k < budget), 1);
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n0 = pulses.size();
    int k  = 0;
    while (pulses.size() == n0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_pulse_tmo"}, 32'(pulses.size() > n0), 1);
    if (pulses.size() > n0) chk({tag, "_pulse_len"}, pulses[$], 4);
  endtask

  task automatic check_stream(input string tag);
    int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    chk({tag, "_beats"}, got.size(), exp_q.size());
    for (int i = 0; i < n; i++) chk(tag, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_pending", pending, 0);
    chk("rst_full", full, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_waddr", rst_waddr, 0);

    // 64-byte packet in slot 0, consumer always ready; check first-beat latency
    mode = 0;
    send_pkt(64);
    begin
      int k = 0;
      while (!tvalid && k < 20) begin
        tick();
        k++;
      end
      chk("first_beat_lat", k, 4);
    end
    end_pkt();
    wait_done("p64", 300);
    wait_pulse("p64", 50);
    check_stream("p64_data");

    // Three packets with ready toggling; slots 0,1,2
    mode = 1;
    pkt(10);
    pkt(20);
    pkt(30);
    wait_done("p3", 400);
    mode = 0;
    wait_pulse("p3", 50);
    check_stream("p3_data");
    chk("p3_hold", hold_viol, 0);

    // Randomized lengths, gaps and backpressure
    mode = 2;
    for (int n = 0; n < 8; n++) begin
      pkt(int'($urandom_range(1, 40)));
      repeat ($urandom_range(0, 30)) tick();
    end
    wait_done("rnd", 2000);
    mode = 0;
    wait_pulse("rnd", 50);
    check_stream("rnd_data");
    chk("rnd_hold", hold_viol, 0);

    // Zero-length packet
    send_pkt(0);
    chk("z_pend1", pending, 1);
    begin
      int k = 0;
      while (pending != 0 && k < 10) begin
        tick();
        k++;
      end
      chk("z_pend0_tmo", 32'(k < 10), 1);
    end
    end_pkt();
    wait_pulse("z", 50);
    chk("z_beats", got.size(), 0);
    check_stream("z_data");

    // Packet arriving during the waddr reset window goes to slot 0
    pkt(5);
    wait_done("w0", 100);
    begin
      int k = 0;
      while (!rst_waddr && k < 20) begin
        tick();
        k++;
      end
      chk("w_pulse_seen", rst_waddr, 1);
    end
    raise_valid(12);
    rx_valid = 1'b0;
    tick();
    wait_done("w1", 100);
    wait_pulse("w1", 50);
    check_stream("w_data");

    // Fill all slots with the consumer stalled; 63rd packet is dropped
    mode = 3;
    tready = 1'b0;
    for (int n = 1; n <= 63; n++) begin
      pkt(int'($urandom_range(1, 6)));
      if (n == 61) chk("full_61", full, 0);
      if (n == 62) chk("full_62", full, 1);
    end
    chk("full_63", full, 1);
    chk("full_drop", drop_count, 32'(drop_m));
    chk("full_pending", pending, 62);
    mode = 0;
    wait_done("full", 3000);
    wait_pulse("full", 50);
    chk("full_clr", full, 0);
    check_stream("full_data");
    chk("full_hold", hold_viol, 0);

    // Synchronous reset mid-stream
    pkt(100);
    begin
      int k = 0;
      while (got.size() < 5 && k < 100) begin
        tick();
        k++;
      end
      chk("mid_tmo", 32'(k < 100), 1);
    end
    rst = 1'b1;
    tick();
    chk("mid_tvalid", tvalid, 0);
    chk("mid_pending", pending, 0);
    chk("mid_drop", drop_count, 0);
    chk("mid_full", full, 0);
    chk("mid_addr", mem_rd_addr, 0);
    rst = 1'b0;
    got.delete();
    exp_q.delete();
    rx_slot = 0;
    drop_m  = 0;
    tick();

    // Recovery after reset starts again at slot 0
    pkt(3);
    wait_done("rec", 100);
    wait_pulse("rec", 50);
    check_stream("rec_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
